// File: rtl/fft_addr_gen_if.sv
// Handshake/configuration bundle between an FFT address consumer and fft_addr_gen.
// master = requester/consumer side, slave = generator side.
interface fft_addr_gen_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) ();
    logic              start;
    logic [ADDR_W-1:0] offset;
    logic [CNT_W-1:0]  filesize;
    logic [2:0]        shift;
    logic              mode;
    logic [4:0]        lg_n;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, offset, filesize, shift, mode, lg_n, addr_ready,
        input  addr, addr_valid, busy, done
    );

    modport slave (
        input  start, offset, filesize, shift, mode, lg_n, addr_ready,
        output addr, addr_valid, busy, done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Three-stage (index, transform, add) FFT address generator with valid/ready output.
// Optional bit-reversed indexing is enabled by defining FFT_ADDR_BITREV_EN.
module fft_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    fft_addr_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, fs_q, idx_q, sel_idx_s;
    logic [ADDR_W-1:0] offset_q, t_q, addr_q, t_d, addr_d;
    logic [2:0]        shift_q;
    logic              v1_q, v2_q, v3_q;
    logic              done_q, done_d;
    logic              adv_s, load_s, issue_s;

    assign adv_s = !v3_q || bus.addr_ready;

`ifdef FFT_ADDR_BITREV_EN
    logic       mode_q;
    logic [4:0] lg_n_q;

    // Reverse bits [n-1:0], keep the upper bits; constant indices keep it a pure mux tree.
    function automatic logic [CNT_W-1:0] bitrev_f(input logic [CNT_W-1:0] v, input logic [4:0] n);
        logic [CNT_W-1:0] r;
        r = v;
        for (int i = 0; i < CNT_W; i++) begin
            for (int j = 0; j < CNT_W; j++) begin
                if ((i < int'(n)) && ((i + j) == (int'(n) - 1))) begin
                    r[i] = v[j];
                end
            end
        end
        return r;
    endfunction

    // Index selection for the transform stage
    always_comb begin
        sel_idx_s = idx_q;
        if (mode_q) begin
            sel_idx_s = bitrev_f(idx_q, lg_n_q);
        end else begin
            sel_idx_s = idx_q;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{bus.mode, bus.lg_n};
    assign sel_idx_s    = idx_q;
`endif

    assign t_d    = ADDR_W'(sel_idx_s) << shift_q;
    assign addr_d = offset_q + t_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter issue and done request
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        issue_s = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.filesize != '0)) begin
                    load_s  = 1'b1;
                    state_d = RUN;
                end else if (bus.start) begin
                    done_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (adv_s) begin
                    issue_s = 1'b1;
                    if (cnt_q == (fs_q - CNT_ONE)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Only the add stage can still hold data once the earlier stages are empty.
                if (!v1_q && !v2_q && v3_q && bus.addr_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration capture, index counter and the three pipeline stages
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            fs_q     <= '0;
            offset_q <= '0;
            shift_q  <= 3'd0;
            idx_q    <= '0;
            t_q      <= '0;
            addr_q   <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef FFT_ADDR_BITREV_EN
            mode_q   <= 1'b0;
            lg_n_q   <= 5'd0;
`endif
        end else begin
            done_q <= done_d;
            if (load_s) begin
                cnt_q    <= '0;
                fs_q     <= bus.filesize;
                offset_q <= bus.offset;
                shift_q  <= bus.shift;
`ifdef FFT_ADDR_BITREV_EN
                mode_q   <= bus.mode;
                lg_n_q   <= bus.lg_n;
`endif
            end else if (issue_s) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (adv_s) begin
                v1_q  <= issue_s;
                idx_q <= cnt_q;
                v2_q  <= v1_q;
                t_q   <= t_d;
                v3_q  <= v2_q;
                if (v2_q) begin
                    addr_q <= addr_d;
                end
            end
        end
    end

    assign bus.addr       = addr_q;
    assign bus.addr_valid = v3_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: stimulus pushes expected addresses, a negedge monitor pops and compares.
module tb_fft_addr_gen;
    localparam int AW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_addr_gen_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
    fft_addr_gen #(.ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [AW-1:0] exp_q[$];
    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every handshake against the scoreboard and check stall stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {31'd0, bus.addr_valid, bus.addr}, {31'd0, 1'b1, prev_addr});
            end
            if (bus.addr_valid && bus.addr_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_addr: got %0h expected none", bus.addr);
                end else begin
                    chk("addr", {32'd0, bus.addr}, {32'd0, exp_q.pop_front()});
                end
            end
            if (bus.done) begin
                done_cnt++;
            end
            prev_stall = bus.addr_valid && !bus.addr_ready;
            prev_addr  = bus.addr;
        end
    end

    task automatic start_seq(input logic [AW-1:0] off, input logic [CW-1:0] fs,
                             input logic [2:0] sh, input logic md, input logic [4:0] ln);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.offset   = off;
        bus.filesize = fs;
        bus.shift    = sh;
        bus.mode     = md;
        bus.lg_n     = ln;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 300);
        chk({name, "_done_seen"}, {63'd0, bus.done}, 64'd1);
        chk({name, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        chk({name, "_done_single"}, {63'd0, bus.done}, 64'd0);
        #1;
    endtask

    int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int pat[3] = '{1, 0, 0};

    initial begin
        int d0;
        int h0;
        int n;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.offset     = '0;
        bus.filesize   = '0;
        bus.shift      = 3'd0;
        bus.mode       = 1'b0;
        bus.lg_n       = 5'd0;
        bus.addr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", {32'd0, bus.addr}, 64'd0);
        chk("rst_valid", {63'd0, bus.addr_valid}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        rst = 1'b0;

        // Linear sequence with latency check
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
        start_seq(32'h1000, 16'd4, 3'd2, 1'b0, 5'd0);
        @(negedge clk);
        chk("lat_n0_valid", {63'd0, bus.addr_valid}, 64'd0);
        chk("run_busy", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        chk("lat_n1_valid", {63'd0, bus.addr_valid}, 64'd0);
        @(negedge clk);
        chk("lat_n2_valid", {63'd0, bus.addr_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat_stream_valid", {63'd0, bus.addr_valid}, 64'd1);
        end
        wait_done("lin");
        chk("lin_done_count", 64'(done_cnt - d0), 64'd1);

        // Bit-reversed request (linear when the feature is compiled out)
        for (int i = 0; i < 8; i++) begin
`ifdef FFT_ADDR_BITREV_EN
            exp_q.push_back(32'(br[i]));
`else
            exp_q.push_back(32'(i));
`endif
        end
        start_seq(32'h0, 16'd8, 3'd0, 1'b1, 5'd3);
        wait_done("brev");

        // Backpressure with ready pattern 1,0,0
        d0 = done_cnt;
        h0 = hs_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        start_seq(32'h0, 16'd4, 3'd0, 1'b0, 5'd0);
        for (int k = 0; k < 100 && done_cnt == d0; k++) begin
            bus.addr_ready = pat[k % 3][0];
            @(posedge clk);
            #1;
        end
        bus.addr_ready = 1'b1;
        chk("bp_done_count", 64'(done_cnt - d0), 64'd1);
        chk("bp_handshakes", 64'(hs_cnt - h0), 64'd4);

        // Address wrap-around
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        start_seq(32'hFFFF_FFFC, 16'd3, 3'd2, 1'b0, 5'd0);
        wait_done("wrap");

        // Zero-length request
        start_seq(32'h0, 16'd0, 3'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("zero_done", {63'd0, bus.done}, 64'd1);
        chk("zero_valid", {63'd0, bus.addr_valid}, 64'd0);
        chk("zero_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        chk("zero_done_single", {63'd0, bus.done}, 64'd0);

        // Second start during RUN must be ignored
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h2000 + 32'(i));
        start_seq(32'h2000, 16'd4, 3'd0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.offset   = 32'h5000;
        bus.filesize = 16'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ign");
        repeat (5) @(negedge clk);
        chk("ign_idle_valid", {63'd0, bus.addr_valid}, 64'd0);
        chk("ign_idle_busy", {63'd0, bus.busy}, 64'd0);
        chk("ign_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-sequence
        h0 = hs_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h3000 + 32'(4 * i));
        start_seq(32'h3000, 16'd8, 3'd2, 1'b0, 5'd0);
        n = 0;
        while (hs_cnt < h0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reached", {63'd0, (hs_cnt >= h0 + 2)}, 64'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", {63'd0, bus.addr_valid}, 64'd0);
        chk("rstmid_busy", {63'd0, bus.busy}, 64'd0);
        chk("rstmid_done", {63'd0, bus.done}, 64'd0);
        repeat (5) @(negedge clk);
        chk("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        start_seq(32'h0, 16'd4, 3'd0, 1'b0, 5'd0);
        wait_done("after_rst");

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
